// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI byte path: FSM states, pin levels and
// default timing.
package oled_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } spi_state_e;

    // SPI clock level while no byte is being shifted
    localparam logic SPI_IDLE_LVL = 1'b1;

    // System-clock cycles per SPI half-period (100 MHz / 10 = 10 MHz SPI)
    localparam int unsigned DEFAULT_CLK_DIV = 5;

    // D/C line encoding
    localparam logic DC_COMMAND = 1'b0;
    localparam logic DC_DATA    = 1'b1;

    localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/oled_spi_tick.sv
// Half-period timer for the SPI clock: a 1-cycle strobe every CLK_DIV cycles
// while enabled, held at zero while cleared.
module oled_spi_tick
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/oled_spi_byte_tx.sv
// Byte-level SPI transmitter for the OLED panel: accepts one byte plus D/C
// flag per request and shifts it out MSB-first (SPI clock idles high).
module oled_spi_byte_tx
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] sendData,
    input  logic       sendDataValid,
    input  logic       sendDc,
    output logic       sendDone,
    output logic       busy,
    output logic       oled_spi_clk,
    output logic       oled_spi_data,
    output logic       oled_dc_n
);

    // Asynchronous assertion, synchronous release of the internal reset
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    spi_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       start_q, start_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       dc_q, dc_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    logic tick_en;
    logic tick_clr;
    logic tick;

    assign tick_en  = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign tick_clr = !tick_en;

    oled_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clock),
        .rst_n  (rst_n),
        .enable (tick_en),
        .clear  (tick_clr),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        start_d   = start_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        dc_d      = dc_q;
        done_d    = done_q;
        busy_d    = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                // Acceptance is split over two edges: capture, then the first
                // falling SPI edge one cycle later from the captured byte.
                if (start_q) begin
                    start_d   = 1'b0;
                    state_d   = ST_LOW;
                    sclk_d    = 1'b0;
                    mosi_d    = shift_q[7];
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                end else if (sendDataValid && !done_q) begin
                    shift_d = sendData;
                    dc_d    = sendDc;
                    start_d = 1'b1;
                end
            end

            ST_LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (tick) begin
                    if (bit_cnt_q == 3'(BITS_PER_BYTE - 1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        mosi_d    = shift_q[6];
                        sclk_d    = 1'b0;
                        state_d   = ST_LOW;
                    end
                end
            end

            ST_DONE: begin
                if (!sendDataValid) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            start_q   <= 1'b0;
            sclk_q    <= SPI_IDLE_LVL;
            mosi_q    <= 1'b0;
            dc_q      <= DC_COMMAND;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            start_q   <= start_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            dc_q      <= dc_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign sendDone      = done_q;
    assign busy          = busy_q;
    assign oled_spi_clk  = sclk_q;
    assign oled_spi_data = mosi_q;
    assign oled_dc_n     = dc_q;

endmodule

// File: tb/tb_oled_spi_byte_tx.sv
// Self-checking bench for oled_spi_byte_tx with CLK_DIV=2: table of byte
// requests plus hand-written back-to-back, mid-change, early-drop and reset cases.
module tb_oled_spi_byte_tx;

    localparam int unsigned CD = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sendData = 8'h00;
    logic       sendDataValid = 1'b0;
    logic       sendDc = 1'b0;
    logic       sendDone;
    logic       busy;
    logic       oled_spi_clk;
    logic       oled_spi_data;
    logic       oled_dc_n;

    oled_spi_byte_tx #(
        .CLK_DIV (CD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sendData      (sendData),
        .sendDataValid (sendDataValid),
        .sendDc        (sendDc),
        .sendDone      (sendDone),
        .busy          (busy),
        .oled_spi_clk  (oled_spi_clk),
        .oled_spi_data (oled_spi_data),
        .oled_dc_n     (oled_dc_n)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] b;
        logic       dc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         hold;
        logic [7:0] exp_byte;
        logic       exp_dc;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         rx_cnt        = 0;
    logic [7:0] rx_shift      = 8'h00;
    logic       prev_sclk     = 1'b1;
    logic       prev_done     = 1'b0;
    int         sclk_falls    = 0;
    int         last_fall_cyc = 0;
    int         done_rises    = 0;
    int         done_rise_cyc = 0;
    int         done_len      = 0;
    int         last_done_len = 0;
    int         last_done_fall_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Line monitor: samples on the falling system-clock edge
    always @(negedge clock) begin
        if (!reset) begin
            rx_cnt    = 0;
            prev_sclk = 1'b1;
            prev_done = 1'b0;
        end else begin
            if (oled_spi_clk && !prev_sclk) begin
                rx_shift = {rx_shift[6:0], oled_spi_data};
                rx_cnt++;
            end
            if (!oled_spi_clk && prev_sclk) begin
                sclk_falls++;
                last_fall_cyc = cyc;
            end
            if (sendDone && !prev_done) begin
                done_rises++;
                done_rise_cyc = cyc;
                done_len = 0;
                chk("done_has_request", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rise_count", rx_cnt, 8);
                    chk("mosi_byte", {24'h0, rx_shift}, {24'h0, mon_e.b});
                    chk("dc_at_done", {31'h0, oled_dc_n}, {31'h0, mon_e.dc});
                end
                rx_cnt = 0;
            end
            if (sendDone) done_len++;
            if (!sendDone && prev_done) begin
                last_done_len = done_len;
                last_done_fall_cyc = cyc;
            end
            prev_sclk = oled_spi_clk;
            prev_done = sendDone;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_done(input int max, input string name);
        int n;
        n = 0;
        while (!sendDone && n < max) begin
            tick();
            n++;
        end
        chk(name, {31'h0, sendDone}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int drive_cyc;
        int f0;
        chk("idle_sclk", {31'h0, oled_spi_clk}, 32'd1);
        chk("idle_busy", {31'h0, busy}, 32'd0);
        sendData      = v.data;
        sendDc        = v.dc;
        sendDataValid = 1'b1;
        exp_q.push_back('{b: v.exp_byte, dc: v.exp_dc});
        drive_cyc = cyc;
        f0 = sclk_falls;
        wait_done(40 * CD + 20, "done_timeout");
        chk("done_latency", done_rise_cyc - drive_cyc, 2 + 16 * CD);
        chk("fall_count", sclk_falls - f0, 8);
        repeat (v.hold) tick();
        chk("done_held", {31'h0, sendDone}, 32'd1);
        chk("busy_held", {31'h0, busy}, 32'd1);
        chk("no_restart", sclk_falls - f0, 8);
        chk("sclk_idle_done", {31'h0, oled_spi_clk}, 32'd1);
        sendDataValid = 1'b0;
        tick();
        chk("done_drop", {31'h0, sendDone}, 32'd0);
        chk("busy_drop", {31'h0, busy}, 32'd0);
        chk("dc_hold", {31'h0, oled_dc_n}, {31'h0, v.exp_dc});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    vec_t vecs[6];

    initial begin
        int n;
        int snap;
        int gap;

        vecs[0] = '{8'hA5, 1'b1, 10, 8'hA5, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, 0,  8'h3C, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 2,  8'h81, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1,  8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b1};
        vecs[5] = '{8'h5A, 1'b0, 3,  8'h5A, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("rst_sclk", {31'h0, oled_spi_clk}, 32'd1);
        chk("rst_mosi", {31'h0, oled_spi_data}, 32'd0);
        chk("rst_dc", {31'h0, oled_dc_n}, 32'd0);
        chk("rst_done", {31'h0, sendDone}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        reset = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            tick();
        end

        // Back-to-back: 0x00/cmd then 0xFF/data, upstream reacting in one cycle
        sendData = 8'h00; sendDc = 1'b0; sendDataValid = 1'b1;
        exp_q.push_back('{b: 8'h00, dc: 1'b0});
        wait_done(40 * CD + 20, "b2b_first_done");
        sendDataValid = 1'b0;
        tick();
        chk("b2b_done_low", {31'h0, sendDone}, 32'd0);
        sendData = 8'hFF; sendDc = 1'b1; sendDataValid = 1'b1;
        exp_q.push_back('{b: 8'hFF, dc: 1'b1});
        snap = sclk_falls;
        chk("b2b_dc_before", {31'h0, oled_dc_n}, 32'd0);
        tick();
        chk("b2b_dc_after", {31'h0, oled_dc_n}, 32'd1);
        n = 0;
        while (sclk_falls == snap && n < 6) begin
            tick();
            n++;
        end
        gap = last_fall_cyc - last_done_fall_cyc;
        chk("b2b_first_fall_seen", (sclk_falls > snap) ? 32'd1 : 32'd0, 32'd1);
        chk("b2b_gap_le3", (gap <= 3 && gap >= 2) ? 32'd1 : 32'd0, 32'd1);
        wait_done(40 * CD + 20, "b2b_second_done");
        sendDataValid = 1'b0;
        tick();
        tick();

        // sendData/sendDc change mid-transfer are ignored
        sendData = 8'h81; sendDc = 1'b0; sendDataValid = 1'b1;
        exp_q.push_back('{b: 8'h81, dc: 1'b0});
        repeat (10) tick();
        sendData = 8'h3C; sendDc = 1'b1;
        wait_done(40 * CD + 20, "midchg_done");
        sendDataValid = 1'b0;
        tick();
        chk("midchg_dc_hold", {31'h0, oled_dc_n}, 32'd0);
        tick();

        // Valid dropped after bit 2: byte completes, sendDone pulses one cycle
        sendData = 8'hC3; sendDc = 1'b1; sendDataValid = 1'b1;
        exp_q.push_back('{b: 8'hC3, dc: 1'b1});
        n = 0;
        while (rx_cnt < 2 && n < 100) begin
            tick();
            n++;
        end
        chk("drop_reached_bit2", rx_cnt, 2);
        sendDataValid = 1'b0;
        wait_done(40 * CD + 20, "drop_done");
        tick();
        chk("drop_pulse_len", last_done_len, 1);
        chk("drop_done_low", {31'h0, sendDone}, 32'd0);
        chk("drop_busy_low", {31'h0, busy}, 32'd0);
        snap = sclk_falls;
        repeat (6) tick();
        chk("drop_no_restart", sclk_falls - snap, 0);

        // Reset after 3 bits of 0xF0
        sendData = 8'hF0; sendDc = 1'b1; sendDataValid = 1'b1;
        exp_q.push_back('{b: 8'hF0, dc: 1'b1});
        n = 0;
        while (rx_cnt < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("rstmid_reached_bit3", rx_cnt, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_sclk", {31'h0, oled_spi_clk}, 32'd1);
        chk("rstmid_mosi", {31'h0, oled_spi_data}, 32'd0);
        chk("rstmid_busy", {31'h0, busy}, 32'd0);
        chk("rstmid_dc", {31'h0, oled_dc_n}, 32'd0);
        exp_q.delete();
        sendDataValid = 1'b0;
        snap = done_rises;
        repeat (5) tick();
        reset = 1'b1;
        repeat (5) tick();
        chk("rstmid_no_done", done_rises - snap, 0);
        run_vec('{8'h5A, 1'b0, 1, 8'h5A, 1'b0});
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
